// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, flag bit positions and per-opcode flag write mask
package alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD    = 4'd0;
  localparam opcode_t OP_SUB    = 4'd1;
  localparam opcode_t OP_XOR    = 4'd2;
  localparam opcode_t OP_RED    = 4'd3;
  localparam opcode_t OP_SLL    = 4'd4;
  localparam opcode_t OP_SRA    = 4'd5;
  localparam opcode_t OP_ROR    = 4'd6;
  localparam opcode_t OP_PADDSB = 4'd7;
  localparam opcode_t OP_LW     = 4'd8;
  localparam opcode_t OP_SW     = 4'd9;
  localparam opcode_t OP_LLB    = 4'd10;
  localparam opcode_t OP_LHB    = 4'd11;
  localparam opcode_t OP_PCS    = 4'd14;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Which of {N,V,Z} an opcode is allowed to overwrite when it commits.
  function automatic logic [2:0] flag_mask(input opcode_t op);
    logic [2:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        m[FLAG_N] = 1'b1;
        m[FLAG_V] = 1'b1;
        m[FLAG_Z] = 1'b1;
      end
      OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath: result, signed overflow and flag write mask
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMMW  = WIDTH / 2
) (
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IMMW-1:0]  imm,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] result,
  output logic             v,
  output logic [2:0]       mask
);

  localparam int SHW    = $clog2(WIDTH);
  localparam int LANES8 = WIDTH / 8;
  localparam int LANES4 = WIDTH / 4;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] red;
  logic [WIDTH-1:0] psat;
  logic [WIDTH-1:0] ror_r;
  logic [WIDTH-1:0] ls_addr;
  logic [4:0]       lane_sum;

  assign sh = imm[SHW-1:0];

  always_comb begin
    sum     = a + b;
    diff    = a - b;
    ror_r   = (a >> sh) | (a << (WIDTH - int'(sh)));
    ls_addr = {b[WIDTH-1:1], 1'b0} + (WIDTH'($signed(imm[3:0])) << 1);

    red = '0;
    for (int i = 0; i < LANES8; i++) begin
      red = red + WIDTH'($signed(a[8*i +: 8])) + WIDTH'($signed(b[8*i +: 8]));
    end

    // 5-bit lane sum: bits 4 and 3 disagree exactly when the nibble overflowed.
    psat     = '0;
    lane_sum = '0;
    for (int i = 0; i < LANES4; i++) begin
      lane_sum = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
      if (lane_sum[4] != lane_sum[3]) psat[4*i +: 4] = lane_sum[4] ? 4'h8 : 4'h7;
      else                            psat[4*i +: 4] = lane_sum[3:0];
    end
  end

  always_comb begin
    result = '0;
    v      = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum;
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:        result = a ^ b;
      OP_RED:        result = red;
      OP_SLL:        result = a << sh;
      OP_SRA:        result = WIDTH'($signed(a) >>> sh);
      OP_ROR:        result = ror_r;
      OP_PADDSB:     result = psat;
      OP_LW, OP_SW:  result = ls_addr;
      OP_LLB:        result = {a[WIDTH-1:IMMW], imm};
      OP_LHB:        result = {imm, a[IMMW-1:0]};
      OP_PCS:        result = pc + WIDTH'(2);
      default:       result = '0;
    endcase
  end

  assign mask = flag_mask(opcode);

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline with committed N/V/Z flag register
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMMW  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IMMW-1:0]  imm,
  input  logic [WIDTH-1:0] pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       out_opcode,
  output logic [2:0]       flags
);

  logic             s1_valid;
  opcode_t          s1_opcode;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [IMMW-1:0]  s1_imm;
  logic [WIDTH-1:0] s1_pc;

  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] core_result;
  logic             core_v;
  logic [2:0]       core_mask;
  logic [2:0]       nvz_new;

  // No skid buffer: S1 frees up only in the cycle S2 takes its contents.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_imm    <= '0;
      s1_pc     <= '0;
    end else if (s1_load) begin
      s1_valid  <= 1'b1;
      s1_opcode <= opcode;
      s1_a      <= a;
      s1_b      <= b;
      s1_imm    <= imm;
      s1_pc     <= pc;
    end else if (s2_load) begin
      s1_valid  <= 1'b0;
    end
  end

  alu_core #(
    .WIDTH (WIDTH),
    .IMMW  (IMMW)
  ) u_core (
    .opcode (s1_opcode),
    .a      (s1_a),
    .b      (s1_b),
    .imm    (s1_imm),
    .pc     (s1_pc),
    .result (core_result),
    .v      (core_v),
    .mask   (core_mask)
  );

  always_comb begin
    nvz_new         = '0;
    nvz_new[FLAG_N] = core_result[WIDTH-1];
    nvz_new[FLAG_V] = core_v;
    nvz_new[FLAG_Z] = (core_result == '0);
  end

  // Flags commit on the same edge the producing result enters S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      out_opcode <= '0;
      flags      <= '0;
    end else if (s2_load) begin
      out_valid  <= 1'b1;
      result     <= core_result;
      out_opcode <= s1_opcode;
      flags      <= (flags & ~core_mask) | (nvz_new & core_mask);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe at WIDTH=16
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  imm;
  logic [15:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  out_opcode;
  logic [2:0]  flags;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .IMMW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .imm        (imm),
    .pc         (pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_opcode (out_opcode),
    .flags      (flags)
  );

  // Issues one op into an idle pipe and captures what it produces; starts and ends 1 time unit after a posedge.
  task automatic run_op(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb,
                        input logic [7:0] vi, input logic [15:0] vpc,
                        output logic [15:0] res, output logic [2:0] fl, output logic [3:0] opc,
                        output logic [2:0] fl_pre, output int lat);
    opcode = op; a = va; b = vb; imm = vi; pc = vpc;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fl_pre = flags;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result; fl = flags; opc = out_opcode;
    if (!out_valid) begin
      vectors++; errors++;
      $display("FAIL run_op timeout: op=%0d out_valid=%b required 1", op, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; a = '0; b = '0; imm = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (result !== 16'h0000)  begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
    vectors++; if (out_opcode !== 4'h0)  begin errors++; $display("FAIL reset_out_opcode: got %h want 0", out_opcode); end
    vectors++; if (flags !== 3'b000)     begin errors++; $display("FAIL reset_flags: got %b want 000", flags); end
  endtask

  task automatic test_add();
    logic [15:0] res; logic [2:0] fl, fl_pre; logic [3:0] opc; int lat;
    run_op(4'd0, 16'h7FFF, 16'h0001, 8'h00, 16'h0000, res, fl, opc, fl_pre, lat);
    vectors++; if (res !== 16'h8000)  begin errors++; $display("FAIL add_result: got %h want 8000", res); end
    vectors++; if (fl !== 3'b110)     begin errors++; $display("FAIL add_flags: got %b want 110", fl); end
    vectors++; if (opc !== 4'd0)      begin errors++; $display("FAIL add_opcode: got %h want 0", opc); end
    vectors++; if (lat !== 1)         begin errors++; $display("FAIL add_latency: got %0d edges want 1", lat); end
    vectors++; if (fl_pre !== 3'b000) begin errors++; $display("FAIL add_flags_early: got %b want 000", fl_pre); end
  endtask

  task automatic test_sub_xor();
    logic [3:0]  t_op [5] = '{4'd1, 4'd2, 4'd0, 4'd2, 4'd2};
    logic [15:0] t_a  [5] = '{16'h0005, 16'h1234, 16'h7FFF, 16'h1234, 16'h0001};
    logic [15:0] t_b  [5] = '{16'h0005, 16'h1234, 16'h0001, 16'h0000, 16'h0001};
    logic [15:0] t_r  [5] = '{16'h0000, 16'h0000, 16'h8000, 16'h1234, 16'h0000};
    logic [2:0]  t_f  [5] = '{3'b001, 3'b001, 3'b110, 3'b110, 3'b111};
    logic [15:0] res; logic [2:0] fl, fl_pre; logic [3:0] opc; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 8'h00, 16'h0000, res, fl, opc, fl_pre, lat);
      vectors++; if (res !== t_r[i])  begin errors++; $display("FAIL subxor_result[%0d]: got %h want %h", i, res, t_r[i]); end
      vectors++; if (fl !== t_f[i])   begin errors++; $display("FAIL subxor_flags[%0d]: got %b want %b", i, fl, t_f[i]); end
      vectors++; if (opc !== t_op[i]) begin errors++; $display("FAIL subxor_opcode[%0d]: got %h want %h", i, opc, t_op[i]); end
    end
  endtask

  task automatic test_paddsb();
    logic [15:0] t_a [3] = '{16'h7777, 16'h8888, 16'h1234};
    logic [15:0] t_b [3] = '{16'h1111, 16'hFFFF, 16'h1111};
    logic [15:0] t_r [3] = '{16'h7777, 16'h8888, 16'h2345};
    logic [15:0] res; logic [2:0] fl, fl_pre; logic [3:0] opc; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(4'd7, t_a[i], t_b[i], 8'h00, 16'h0000, res, fl, opc, fl_pre, lat);
      vectors++; if (res !== t_r[i]) begin errors++; $display("FAIL paddsb_result[%0d]: got %h want %h", i, res, t_r[i]); end
      vectors++; if (fl !== 3'b111)  begin errors++; $display("FAIL paddsb_flags[%0d]: got %b want 111", i, fl); end
    end
  endtask

  task automatic test_shift_red();
    logic [3:0]  t_op  [6] = '{4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd6};
    logic [15:0] t_a   [6] = '{16'h01FF, 16'h0001, 16'h8000, 16'h8000, 16'h0001, 16'h00F0};
    logic [15:0] t_b   [6] = '{16'h8002, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [7:0]  t_imm [6] = '{8'h00, 8'h04, 8'h01, 8'h0F, 8'h01, 8'h14};
    logic [15:0] t_r   [6] = '{16'hFF82, 16'h0010, 16'h0000, 16'hFFFF, 16'h8000, 16'h000F};
    logic [2:0]  t_f   [6] = '{3'b110, 3'b110, 3'b111, 3'b110, 3'b110, 3'b110};
    logic [15:0] res; logic [2:0] fl, fl_pre; logic [3:0] opc; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_imm[i], 16'h0000, res, fl, opc, fl_pre, lat);
      vectors++; if (res !== t_r[i]) begin errors++; $display("FAIL shift_result[%0d]: got %h want %h", i, res, t_r[i]); end
      vectors++; if (fl !== t_f[i])  begin errors++; $display("FAIL shift_flags[%0d]: got %b want %b", i, fl, t_f[i]); end
    end
  endtask

  task automatic test_mem_imm();
    logic [3:0]  t_op  [7] = '{4'd8, 4'd9, 4'd14, 4'd10, 4'd11, 4'd12, 4'd15};
    logic [15:0] t_a   [7] = '{16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'hABCD, 16'hFFFF, 16'hFFFF};
    logic [15:0] t_b   [7] = '{16'h1001, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    logic [7:0]  t_imm [7] = '{8'h0F, 8'h03, 8'h00, 8'h12, 8'h12, 8'hFF, 8'hFF};
    logic [15:0] t_pc  [7] = '{16'h0000, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
    logic [15:0] t_r   [7] = '{16'h0FFE, 16'h0016, 16'h0000, 16'hAB12, 16'h12CD, 16'h0000, 16'h0000};
    logic [15:0] res; logic [2:0] fl, fl_pre; logic [3:0] opc; int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_imm[i], t_pc[i], res, fl, opc, fl_pre, lat);
      vectors++; if (res !== t_r[i])  begin errors++; $display("FAIL mem_result[%0d]: got %h want %h", i, res, t_r[i]); end
      vectors++; if (fl !== 3'b110)   begin errors++; $display("FAIL mem_flags[%0d]: got %b want 110", i, fl); end
      vectors++; if (opc !== t_op[i]) begin errors++; $display("FAIL mem_opcode[%0d]: got %h want %h", i, opc, t_op[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] t_a [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] t_r [4] = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};
    logic [15:0] got_r [4];
    int sent = 0;
    int got = 0;
    int last_cyc = -1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_valid = (sent < 4);
      if (sent < 4) begin opcode = 4'd0; a = t_a[sent]; b = t_a[sent]; imm = '0; pc = '0; end
      out_ready = (cyc >= 4);
      #1;
      if (cyc == 2) begin
        vectors++; if (sent !== 2)        begin errors++; $display("FAIL b2b_accepts: got %0d want 2", sent); end
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full: got %b want 0", in_ready); end
      end
      if (cyc == 3) begin
        vectors++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL b2b_in_ready_hold: got %b want 0", in_ready); end
        vectors++; if (result !== 16'h0002) begin errors++; $display("FAIL b2b_result_hold: got %h want 0002", result); end
        vectors++; if (flags !== 3'b000)    begin errors++; $display("FAIL b2b_flags_hold: got %b want 000", flags); end
      end
      if (out_valid && out_ready) begin got_r[got] = result; got++; last_cyc = cyc; end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (got !== 4)      begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
    vectors++; if (last_cyc !== 7) begin errors++; $display("FAIL b2b_full_rate: last result cycle %0d want 7", last_cyc); end
    for (int i = 0; i < 4 && i < got; i++) begin
      vectors++; if (got_r[i] !== t_r[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got_r[i], t_r[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] res; logic [2:0] fl, fl_pre; logic [3:0] opc; int lat;
    int stale = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    opcode = 4'd0; a = 16'h7FFF; b = 16'h0001; imm = '0; pc = '0;
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0002;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill_valid: got %b want 1", out_valid); end
    vectors++; if (flags !== 3'b110)   begin errors++; $display("FAIL mid_prefill_flags: got %b want 110", flags); end
    rst = 1'b1; out_ready = 1'b1; a = 16'h0005; b = 16'h0005;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    vectors++; if (flags !== 3'b000)    begin errors++; $display("FAIL mid_flags: got %b want 000", flags); end
    vectors++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    vectors++; if (result !== 16'h0000) begin errors++; $display("FAIL mid_result: got %h want 0000", result); end
    for (int i = 0; i < 6; i++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    vectors++; if (stale !== 0) begin errors++; $display("FAIL mid_stale: got %0d stale results want 0", stale); end
    run_op(4'd0, 16'h0003, 16'h0004, 8'h00, 16'h0000, res, fl, opc, fl_pre, lat);
    vectors++; if (res !== 16'h0007) begin errors++; $display("FAIL mid_after_result: got %h want 0007", res); end
    vectors++; if (fl !== 3'b000)    begin errors++; $display("FAIL mid_after_flags: got %b want 000", fl); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_xor();
    test_paddsb();
    test_shift_red();
    test_mem_imm();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
